// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
//   state_e       : controller state encoding (idle = 0, run = 1)
//   DEFAULT_WIDTH : default operand width in bits
package booth_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic {
      StIdle = 1'b0,
      StRun  = 1'b1
   } state_e;

   // Step counter width: must hold the value WIDTH without wrapping.
   function automatic int unsigned cnt_bits(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/booth_seq_mul_if.sv
// Request/result bundle of the Booth multiplier.
//   start        : begin a multiply (accepted only while idle)
//   multiplicand : operand M, two's complement
//   multiplier   : operand Q, two's complement
//   busy         : operation in progress
//   done         : one-cycle pulse, product valid
//   product      : M*Q, two's complement, held until the next completion
// master = requester, slave = multiplier.
interface booth_seq_mul_if
   import booth_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);
   logic               start;
   logic [WIDTH-1:0]   multiplicand;
   logic [WIDTH-1:0]   multiplier;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] product;

   modport master (
      output start, multiplicand, multiplier,
      input  busy, done, product
   );

   modport slave (
      input  start, multiplicand, multiplier,
      output busy, done, product
   );
endinterface

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: conditional add/subtract of M into A
// selected by {Q[0], Q_-1}, followed by an arithmetic right shift of {A, Q, Q_-1}.
//   acc, q, q_m1                : current A (WIDTH+1), Q (WIDTH), Q_-1
//   m                           : sign-extended multiplicand (WIDTH+1)
//   acc_next, q_next, q_m1_next : state after the step
module booth_step
   import booth_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH:0]   acc,
   input  logic [WIDTH-1:0] q,
   input  logic             q_m1,
   input  logic [WIDTH:0]   m,
   output logic [WIDTH:0]   acc_next,
   output logic [WIDTH-1:0] q_next,
   output logic             q_m1_next
);
   logic           do_sub;
   logic           do_op;
   logic [WIDTH:0] m_gated;
   logic [WIDTH:0] m_addend;
   logic [WIDTH:0] sum;

   // 10 -> subtract, 01 -> add, 00/11 -> no change.
   assign do_sub  = q[0] & ~q_m1;
   assign do_op   = q[0] ^ q_m1;
   assign m_gated = do_op ? m : '0;

   // Subtraction as A + ~M + 1: the xor array inverts M, do_sub is the carry-in.
   for (genvar i = 0; i <= WIDTH; i++) begin : g_inv
      xor2 u_xor (
         .a (m_gated[i]),
         .b (do_sub),
         .y (m_addend[i])
      );
   end

   assign sum = acc + m_addend + {{WIDTH{1'b0}}, do_sub};

   // Arithmetic shift right by one of {sum, q, q_m1}; the old q_m1 drops out.
   assign acc_next  = {sum[WIDTH], sum[WIDTH:1]};
   assign q_next    = {sum[0], q[WIDTH-1:1]};
   assign q_m1_next = q[0];
endmodule

// File: rtl/xor2.sv
// Two-input XOR cell.
//   a, b : inputs
//   y    : a ^ b
module xor2 (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a ^ b;
endmodule

// File: rtl/booth_seq_mul.sv
// Sequential radix-2 Booth multiplier, WIDTH cycles per signed multiply.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of booth_seq_mul_if (start/operands in, busy/done/product out)
module booth_seq_mul
   import booth_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic            clk,
   input  logic            rst,
   booth_seq_mul_if.slave  bus
);
   localparam int unsigned CntW = cnt_bits(WIDTH);

   state_e             state_q;
   logic [WIDTH:0]     acc_q;
   logic [WIDTH-1:0]   q_q;
   logic               qm1_q;
   logic [WIDTH:0]     m_q;
   logic [CntW-1:0]    cnt_q;
   logic [2*WIDTH-1:0] product_q;
   logic               busy_q;
   logic               done_q;

   logic [WIDTH:0]     acc_nxt;
   logic [WIDTH-1:0]   q_nxt;
   logic               qm1_nxt;

   booth_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .acc       (acc_q),
      .q         (q_q),
      .q_m1      (qm1_q),
      .m         (m_q),
      .acc_next  (acc_nxt),
      .q_next    (q_nxt),
      .q_m1_next (qm1_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         acc_q     <= '0;
         q_q       <= '0;
         qm1_q     <= 1'b0;
         m_q       <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  m_q     <= {bus.multiplicand[WIDTH-1], bus.multiplicand};
                  acc_q   <= '0;
                  q_q     <= bus.multiplier;
                  qm1_q   <= 1'b0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StRun;
               end
            end
            StRun: begin
               // start is deliberately ignored here.
               acc_q <= acc_nxt;
               q_q   <= q_nxt;
               qm1_q <= qm1_nxt;
               cnt_q <= cnt_q + CntW'(1);
               if (cnt_q == CntW'(WIDTH - 1)) begin
                  product_q <= {acc_nxt[WIDTH-1:0], q_nxt};
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.product = product_q;
endmodule

// File: tb/tb_booth_seq_mul.sv
module tb_booth_seq_mul;
   localparam int unsigned W     = 8;
   localparam int unsigned Lanes = 16;

   logic clk = 1'b0;
   logic rst;
   logic sweep_rst;
   int   errors = 0;
   int   checks = 0;
   logic [Lanes-1:0] lane_done;

   always #5 clk = ~clk;

   booth_seq_mul_if #(.WIDTH(W)) bus ();

   booth_seq_mul #(
      .WIDTH (W)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Signed product straight from integer arithmetic.
   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      int p;
      p = int'($signed(a)) * int'($signed(b));
      return p[2*W-1:0];
   endfunction

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Caller sits at a negedge in an idle or done cycle. Optionally pulses start with
   // other operands at RUN cycle inject_at; those must be ignored.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp, input int inject_at, input string tag);
      logic [2*W-1:0] held;
      int e;
      int busy_n;
      bit held_ok;
      bit overlap;
      held = bus.product;
      bus.start = 1'b1;
      bus.multiplicand = a;
      bus.multiplier = b;
      @(negedge clk);
      bus.start = 1'b0;
      e = 0;
      busy_n = 0;
      held_ok = 1'b1;
      overlap = 1'b0;
      while (!bus.done && e < 12) begin
         if (bus.busy) busy_n++;
         if (bus.product !== held) held_ok = 1'b0;
         bus.start = (e == inject_at);
         if (e == inject_at) begin
            bus.multiplicand = 8'd100;
            bus.multiplier = 8'hCE;
         end
         @(negedge clk);
         e++;
      end
      bus.start = 1'b0;
      if (bus.busy) overlap = 1'b1;
      check({tag, " latency"}, e, 8);
      check({tag, " busy cycles"}, busy_n, 8);
      check({tag, " product held"}, held_ok, 1);
      check({tag, " busy with done"}, overlap, 0);
      check({tag, " product"}, bus.product, exp);
   endtask

   // Exhaustive sweep: each lane covers 16 multiplicands x all 256 multipliers, back-to-back.
   for (genvar g = 0; g < Lanes; g++) begin : g_lane
      booth_seq_mul_if #(.WIDTH(W)) lif ();
      bit fin = 1'b0;
      assign lane_done[g] = fin;

      booth_seq_mul #(
         .WIDTH (W)
      ) u_lane (
         .clk (clk),
         .rst (sweep_rst),
         .bus (lif.slave)
      );

      initial begin
         logic [W-1:0] a;
         logic [W-1:0] b;
         int e;
         lif.start = 1'b0;
         lif.multiplicand = '0;
         lif.multiplier = '0;
         @(negedge clk);
         while (sweep_rst) @(negedge clk);
         for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 256; bi++) begin
               a = 8'(g * 16 + ai);
               b = 8'(bi);
               lif.start = 1'b1;
               lif.multiplicand = a;
               lif.multiplier = b;
               @(negedge clk);
               lif.start = 1'b0;
               e = 0;
               while (!lif.done && e < 12) begin
                  @(negedge clk);
                  e++;
               end
               check($sformatf("sweep %0d*%0d latency", $signed(a), $signed(b)), e, 8);
               check($sformatf("sweep %0d*%0d product", $signed(a), $signed(b)),
                     lif.product, ref_mul(a, b));
            end
         end
         fin = 1'b1;
      end
   end

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] exp;
   } vec_t;

   initial begin
      vec_t vecs[10];
      int guard;
      int done_n;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      vecs[0] = '{8'd7,   8'd3,   16'h0015};
      vecs[1] = '{8'hFB,  8'd3,   16'hFFF1};
      vecs[2] = '{8'h80,  8'h80,  16'h4000};
      vecs[3] = '{8'h80,  8'h7F,  16'hC080};
      vecs[4] = '{8'h7F,  8'h80,  16'hC080};
      vecs[5] = '{8'h00,  8'h55,  16'h0000};
      vecs[6] = '{8'h01,  8'hFF,  16'hFFFF};
      vecs[7] = '{8'h7F,  8'h7F,  16'h3F01};
      vecs[8] = '{8'hFF,  8'hFF,  16'h0001};
      vecs[9] = '{8'h10,  8'hF0,  16'hFF00};

      rst = 1'b1;
      sweep_rst = 1'b1;
      bus.start = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier = '0;
      repeat (3) @(negedge clk);
      check("reset busy", bus.busy, 0);
      check("reset done", bus.done, 0);
      check("reset product", bus.product, 0);

      // First start on the edge right after reset release.
      rst = 1'b0;
      sweep_rst = 1'b0;
      foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, -1, $sformatf("vec%0d", i));

      // Start pulsed mid-run with other operands.
      repeat (2) @(negedge clk);
      run_op(8'd7, 8'd3, 16'h0015, 3, "start in run");

      // Back-to-back: second start in the done cycle; product holds the first result.
      @(negedge clk);
      run_op(8'hFB, 8'd3, 16'hFFF1, -1, "b2b first");
      run_op(8'd12, 8'hF5, 16'hFF7C, -1, "b2b second");

      // Reset at cycle 4 of an operation, with start also high on that edge.
      @(negedge clk);
      bus.start = 1'b1;
      bus.multiplicand = 8'd7;
      bus.multiplier = 8'd3;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("mid reset busy", bus.busy, 0);
      check("mid reset done", bus.done, 0);
      check("mid reset product", bus.product, 0);
      rst = 1'b0;
      done_n = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done || bus.busy) done_n++;
      end
      check("abandoned op activity", done_n, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      run_op(8'd9, 8'd9, 16'h0051, -1, "after reset");

      // Random operands with random idle gaps.
      for (int i = 0; i < 150; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         ra = 8'($urandom);
         rb = 8'($urandom);
         run_op(ra, rb, ref_mul(ra, rb), -1, $sformatf("rand %0d*%0d", $signed(ra), $signed(rb)));
      end

      guard = 0;
      while (lane_done != '1 && guard < 40000) begin
         @(negedge clk);
         guard++;
      end
      check("sweep finished", lane_done, {Lanes{1'b1}});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/booth_seq_mul.md
BOOTH_SEQ_MUL -- requirements
Module: booth_seq_mul

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 4..16.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a multiply; sampled on rising clk edge.
REQ-005 multiplicand  input  WIDTH  signed two's-complement operand M; sampled with accepted start.
REQ-006 multiplier  input  WIDTH  signed two's-complement operand Q; sampled with accepted start.
REQ-007 busy  output  1  high while an operation is in progress.
REQ-008 done  output  1  single-cycle pulse marking product valid.
REQ-009 product  output  2*WIDTH  signed result M*Q; held until the next completion.

Function
REQ-010 The design SHALL be one clock, one synchronous active-high reset; the clock port is clk and the reset port is rst.
REQ-011 FSM states SHALL be IDLE and RUN only.
- IDLE->RUN on start=1.
- RUN->IDLE on the edge performing step WIDTH.
REQ-012 Start SHALL be accepted only in IDLE, or in the done cycle, which is IDLE; start in RUN SHALL be ignored with no effect on operands or result.
REQ-013 On acceptance (edge E0) the block SHALL latch:
- M into a WIDTH+1-bit sign-extended register;
- A := 0 (WIDTH+1 bits), Q := multiplier, Q_-1 := 0, step counter := 0.
REQ-014 Each RUN edge SHALL perform one radix-2 Booth step on {Q[0],Q_-1}:
- 01: A := A+M; 10: A := A-M; 00/11: A unchanged;
- then arithmetic right shift of {A,Q,Q_-1} by one (A MSB replicated);
- then counter += 1.
REQ-015 A SHALL be WIDTH+1 bits so that M = -2^(WIDTH-1) never overflows the add/sub.
REQ-016 At edge E(WIDTH) the block SHALL:
- register product := {A[WIDTH-1:0], Q} after the final shift;
- set done := 1 for exactly one cycle;
- return to IDLE.
REQ-017 Latency SHALL be fixed at WIDTH cycles from the accepting edge to done high and SHALL be independent of operand values.
REQ-018 busy SHALL be 1 in every cycle following E0 up to and including the cycle before done; busy and done SHALL never be 1 together.
REQ-019 product SHALL change only at a completion edge or at reset; it SHALL hold its last value through a subsequent operation until that operation completes.
REQ-020 Back-to-back: start=1 during the done cycle SHALL be accepted, giving done again exactly WIDTH cycles later.
REQ-021 The counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL NOT wrap within an operation.

Reset
REQ-022 rst=1 at any edge SHALL force:
- state IDLE, busy=0, done=0, product=0;
- A, Q, Q_-1, M and counter all 0.
REQ-023 rst SHALL override start on the same edge; an operation in progress SHALL be abandoned with no done pulse.
REQ-024 The first start SHALL be accepted on the edge immediately after rst deasserts.

Structure
REQ-025 Shared package booth_pkg SHALL hold the state encoding (IDLE=0, RUN=1) and the default WIDTH constant.
REQ-026 The add/subtract/shift step SHALL be one combinational sub-module, booth_step, with inputs A, Q, Q_-1, M and outputs next A, Q, Q_-1.
- Subtraction is done as A + ~M + 1, with the inversion built from the existing xor2 cell array.
REQ-027 The FSM, counter, operand registers and product register SHALL live in booth_seq_mul.

Verification (WIDTH=8)
REQ-028 The bench SHALL cover these scenarios:
- 7 x 3 -> done 8 cycles after the accepting edge, product=0x0015; busy high for 8 cycles.
- -5 x 3 -> product=0xFFF1.
- -128 x -128 -> 0x4000; -128 x 127 -> 0xC080.
- Start pulsed during RUN with different operands -> ignored; original result returned on schedule.
- start in the done cycle -> second result 8 cycles later; product holds the first result until then.
- rst asserted at cycle 4 of an operation -> no done pulse; all outputs 0 next cycle; a new start then completes normally.
REQ-029 The bench SHALL run an exhaustive 256x256 sweep against a signed reference model, with zero mismatches required.
